// File: rtl/d_write_buffer_pkg.sv
// rtl/d_write_buffer_pkg.sv - shared CPU types: TLB entry, write-buffer entry, write-buffer issue FSM state
package d_write_buffer_pkg;

  typedef struct packed {
    logic [19:0] vpn;
    logic [19:0] pfn;
    logic [7:0]  asid;
    logic        valid;
    logic        dirty;
    logic        cached;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  size;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_SEND   = 2'd1,
    WB_WAIT_B = 2'd2
  } wbuf_state_t;

  // Every uncached store goes out as a single-beat burst.
  localparam logic [7:0] WB_AWLEN = 8'd0;

endpackage

// File: rtl/wbuf_fifo.sv
// rtl/wbuf_fifo.sv - circular store FIFO with head/tail pointers, exposing all entry addresses for RAW compare
module wbuf_fifo
  import d_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  wbuf_entry_t                i_push_entry,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output wbuf_entry_t                o_head,
  output logic [DEPTH*32-1:0]        o_addr_flat,
  output logic [DEPTH-1:0]           o_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wbuf_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so pointer overflow is the wrap to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_push_entry;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the fill count.
  always_comb begin
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_valid[i] = ({1'b0, PW'(i) - r_head} < r_count);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_addr
    assign o_addr_flat[g*32 +: 32] = r_mem[g].addr;
  end

endmodule

// File: rtl/d_write_buffer.sv
// rtl/d_write_buffer.sv - uncached store buffer issuing single-beat AXI writes; DWB_RAW_CHECK_EN enables per-entry RAW compare
module d_write_buffer
  import d_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_size,
  input  logic [31:0] rd_addr,
  output logic        raw_hit,
  output logic        empty,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE_CNT = (PW+1)'(1);

  wbuf_state_t         r_state;
  wbuf_state_t         w_state_nxt;
  logic                r_aw_done;
  logic                r_w_done;
  logic                w_aw_done_nxt;
  logic                w_w_done_nxt;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_fifo_empty;
  logic [PW:0]         w_count;
  wbuf_entry_t         w_head;
  wbuf_entry_t         w_push_entry;
  logic [DEPTH*32-1:0] w_addr_flat;
  logic [DEPTH-1:0]    w_valid;

  assign w_push_entry = '{addr: req_addr, wdata: req_wdata, wstrb: req_wstrb, size: req_size};
  assign req_ready    = !w_full;
  assign w_push       = req_valid && req_ready;

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_empty      (w_fifo_empty),
    .o_count      (w_count),
    .o_head       (w_head),
    .o_addr_flat  (w_addr_flat),
    .o_valid      (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WB_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (w_count != '0) w_state_nxt = WB_SEND;
      end
      WB_SEND: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if (awvalid && awready) w_aw_done_nxt = 1'b1;
        if (wvalid && wready)   w_w_done_nxt  = 1'b1;
        // Both channels done, possibly in the same cycle: wait for the response.
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt   = WB_WAIT_B;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      WB_WAIT_B: begin
        bready = 1'b1;
        if (bvalid) begin
          w_pop       = 1'b1;
          w_state_nxt = (w_count > ONE_CNT) ? WB_SEND : WB_IDLE;
        end
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  assign awaddr = w_head.addr;
  assign awlen  = WB_AWLEN;
  assign awsize = w_head.size;
  assign wdata  = w_head.wdata;
  assign wstrb  = w_head.wstrb;
  assign wlast  = 1'b1;
  assign empty  = w_fifo_empty && (r_state == WB_IDLE);

`ifdef DWB_RAW_CHECK_EN
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_addr_flat[i*32+2 +: 30] == rd_addr[31:2])) raw_hit = 1'b1;
    end
  end
  logic w_unused;
  assign w_unused = &{1'b0, rd_addr[1:0]};
`else
  // Without comparators any pending store stalls every load.
  assign raw_hit = !empty;
  logic w_unused;
  assign w_unused = &{1'b0, rd_addr, w_addr_flat, w_valid};
`endif

endmodule

// File: tb/tb_d_write_buffer.sv
// tb/tb_d_write_buffer.sv - directed and randomized bench for d_write_buffer against a queue model
module tb_d_write_buffer;

  localparam int DEPTH = 4;
`ifdef DWB_RAW_CHECK_EN
  localparam bit RAW_EN = 1'b1;
`else
  localparam bit RAW_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_size;
  logic [31:0] rd_addr;
  logic        raw_hit;
  logic        empty;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  d_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
    .rd_addr(rd_addr), .raw_hit(raw_hit), .empty(empty),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] z);
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_size  = z;
  endtask

  task automatic wait_bready(input string tag);
    int n = 0;
    while (bready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, bready, 1);
  endtask

  // Reference model: entries in push order plus per-head channel progress.
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  logic [2:0]  q_size[$];
  bit          m_aw;
  bit          m_w;

  function automatic logic model_raw(input logic [31:0] a);
    logic hit = 1'b0;
    foreach (q_addr[i]) if (q_addr[i][31:2] == a[31:2]) hit = 1'b1;
    return RAW_EN ? hit : (q_addr.size() != 0);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got[$];
    logic [31:0] exp_addr;
    logic [31:0] ra;
    bit          took;
    int          n;

    rst = 1'b1; req_valid = 1'b0; set_req('0, '0, '0, '0);
    rd_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_raw_hit", raw_hit, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    rst = 1'b0;
    tick();

    // Single store, B two cycles after W.
    awready = 1'b1; wready = 1'b1;
    req_valid = 1'b1; set_req(32'h1FAF_F000, 32'h1234_5678, 4'hF, 3'd2);
    tick();
    req_valid = 1'b0;
    chk("single_aw_not_early", awvalid, 0);
    chk("single_not_empty", empty, 0);
    tick();
    chk("single_awvalid", awvalid, 1);
    chk("single_wvalid", wvalid, 1);
    chk("single_awaddr", awaddr, 32'h1FAF_F000);
    chk("single_wdata", wdata, 32'h1234_5678);
    chk("single_wstrb", wstrb, 4'hF);
    chk("single_awsize", awsize, 3'd2);
    chk("single_awlen", awlen, 0);
    chk("single_wlast", wlast, 1);
    tick();
    chk("single_aw_dropped", awvalid, 0);
    chk("single_bready", bready, 1);
    tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("single_empty", empty, 1);
    chk("single_bready_off", bready, 0);

    // Fill with AW stalled; the fifth store must wait and drain order must hold.
    awready = 1'b0; wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      set_req(32'h1000_0000 + 32'(i * 16), 32'hA000_0000 + 32'(i), 4'h3, 3'd2);
      tick();
    end
    chk("fill_ready_low", req_ready, 0);
    set_req(32'h1000_0040, 32'hA000_0004, 4'h3, 3'd2);
    tick(); tick(); tick();
    chk("fill_still_held", req_ready, 0);
    chk("fill_head_addr", awaddr, 32'h1000_0000);
    awready = 1'b1; bvalid = 1'b1;
    n = 0;
    while (!(got.size() == 5 && empty && !req_valid) && n < 80) begin
      if (awvalid && awready) got.push_back(awaddr);
      took = req_valid && req_ready;
      tick();
      if (took) req_valid = 1'b0;
      n++;
    end
    chk("fill_retired_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      exp_addr = 32'h1000_0000 + 32'(i * 16);
      chk($sformatf("fill_order_%0d", i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, exp_addr);
    end
    bvalid = 1'b0;

    // Split handshake: W accepted at cycle 0, AW only at cycle 3.
    awready = 1'b0; wready = 1'b1;
    req_valid = 1'b1; set_req(32'h3000_0010, 32'h5555_AAAA, 4'hC, 3'd1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("split_c0_awvalid", awvalid, 1);
    chk("split_c0_wvalid", wvalid, 1);
    tick();
    chk("split_c1_wvalid", wvalid, 0);
    chk("split_c1_awvalid", awvalid, 1);
    chk("split_c1_bready", bready, 0);
    tick();
    chk("split_c2_awvalid", awvalid, 1);
    tick();
    chk("split_c3_awvalid", awvalid, 1);
    chk("split_c3_awaddr", awaddr, 32'h3000_0010);
    chk("split_c3_bready", bready, 0);
    awready = 1'b1;
    tick();
    chk("split_c4_awvalid", awvalid, 0);
    chk("split_c4_bready", bready, 1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("split_empty", empty, 1);

    // RAW check with the store held in the buffer.
    awready = 1'b0; wready = 1'b0;
    req_valid = 1'b1; set_req(32'h1FD0_0004, 32'h0BAD_F00D, 4'hF, 3'd2);
    tick();
    req_valid = 1'b0;
    rd_addr = 32'h1FD0_0006; #1;
    chk("raw_same_word", raw_hit, 1);
    rd_addr = 32'h1FD0_0008; #1;
    chk("raw_next_word", raw_hit, RAW_EN ? 0 : 1);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    n = 0;
    while (!empty && n < 20) begin tick(); n++; end
    chk("raw_drained", empty, 1);
    bvalid = 1'b0;
    rd_addr = 32'h1FD0_0004; #1;
    chk("raw_after_drain", raw_hit, 0);

    // Reset while the head waits for B with three entries queued.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      set_req(32'h4000_0000 + 32'(i * 4), 32'(i), 4'h1, 3'd0);
      tick();
    end
    req_valid = 1'b0;
    wait_bready("rstmid_in_wait_b");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_empty", empty, 1);
    chk("rstmid_awvalid", awvalid, 0);
    chk("rstmid_req_ready", req_ready, 1);
    bvalid = 1'b1;
    req_valid = 1'b1; set_req(32'h2000_0040, 32'h7777_0000, 4'hF, 3'd2);
    tick();
    req_valid = 1'b0;
    got.delete();
    n = 0;
    while (!(got.size() > 0 && empty) && n < 20) begin
      if (awvalid && awready) got.push_back(awaddr);
      tick();
      n++;
    end
    chk("rstmid_reissue_count", got.size(), 1);
    chk("rstmid_reissue_addr", (got.size() > 0) ? got[0] : 32'h0, 32'h2000_0040);
    chk("rstmid_final_empty", empty, 1);
    bvalid = 1'b0;

    // Randomized traffic against the queue model.
    m_aw = 1'b0; m_w = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      set_req(32'h1FD0_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
              $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 2)));
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      bvalid  = ($urandom_range(0, 2) != 0);
      ra = 32'h1FD0_0000 | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
      rd_addr = ra;
      #1;
      chk("rnd_req_ready", req_ready, q_addr.size() < DEPTH);
      chk("rnd_empty", empty, q_addr.size() == 0);
      chk("rnd_raw_hit", raw_hit, model_raw(ra));
      if (q_addr.size() == 0) begin
        chk("rnd_idle_awvalid", awvalid, 0);
        chk("rnd_idle_wvalid", wvalid, 0);
        chk("rnd_idle_bready", bready, 0);
      end else begin
        if (awvalid) begin
          chk("rnd_aw_dup", m_aw, 0);
          chk("rnd_awaddr", awaddr, q_addr[0]);
          chk("rnd_awsize", awsize, q_size[0]);
        end
        if (wvalid) begin
          chk("rnd_w_dup", m_w, 0);
          chk("rnd_wdata", wdata, q_data[0]);
          chk("rnd_wstrb", wstrb, q_strb[0]);
        end
        if (bready) chk("rnd_b_before_aw_w", m_aw && m_w, 1);
      end
      if (awvalid && awready) m_aw = 1'b1;
      if (wvalid && wready)   m_w  = 1'b1;
      if (bready && bvalid && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        void'(q_strb.pop_front());
        void'(q_size.pop_front());
        m_aw = 1'b0;
        m_w  = 1'b0;
      end
      if (req_valid && req_ready) begin
        q_addr.push_back(req_addr);
        q_data.push_back(req_wdata);
        q_strb.push_back(req_wstrb);
        q_size.push_back(req_size);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d_write_buffer.md
D_WRITE_BUFFER -- requirements
Module: d_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_addr in 32, req_wdata in 32, req_wstrb in 4, req_size in 3: one uncached store from the data-side arbitrater.
REQ-005 SHALL have ports rd_addr in 32 (load address to check) and raw_hit out 1 (load must stall until drained).
REQ-006 SHALL have port empty out 1: no entry is queued or in flight.
REQ-007 SHALL have AXI write ports toward the arbitrater: awaddr out 32, awlen out 8, awsize out 3, awvalid out 1, awready in 1, wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1, bvalid in 1, bready out 1.

Function
REQ-008 SHALL store entries in a circular FIFO with head/tail pointers and a count of width clog2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
REQ-009 SHALL assert req_ready = (count < DEPTH) only; a pop in the same cycle does not raise req_ready.
REQ-010 SHALL push on req_valid & req_ready, capturing addr, wdata, wstrb and size.
REQ-011 SHALL run issue FSM IDLE -> SEND -> WAIT_B; IDLE -> SEND when count > 0, registered, so awvalid rises no earlier than the cycle after the first push.
REQ-012 In SEND it SHALL drive awvalid and wvalid from the head entry, track aw_done and w_done independently, drop each valid after its handshake, and go to WAIT_B once both handshakes are done, including the case where both complete in the same cycle.
REQ-013 SHALL drive awlen = 0 and wlast = 1 always; awsize = head size; wdata and wstrb = head entry.
REQ-014 In WAIT_B it SHALL assert bready; on bvalid it SHALL pop the head and go to SEND if count > 1, otherwise to IDLE.
REQ-015 SHALL keep the head entry resident until its B handshake; a push while count = DEPTH-1 and the head is in WAIT_B is accepted normally.
REQ-016 SHALL hold awaddr, wdata, wstrb and awsize stable while the corresponding valid is high and unaccepted.
REQ-017 SHALL drive empty = (count == 0), which also requires the FSM to be in IDLE.
REQ-018 SHALL ignore bresp; each B beat retires exactly one entry, in order.

Reset
REQ-019 On rst, outputs SHALL be: count=0, head=tail=0, FSM=IDLE, awvalid=wvalid=bready=0, req_ready=1, empty=1, raw_hit=0.
REQ-020 On rst mid-transaction, all queued and in-flight entries SHALL be discarded; the whole system resets together, so no outstanding-transaction handling is required.

Configuration
REQ-021 With macro DWB_RAW_CHECK_EN defined, raw_hit SHALL be 1 iff any valid entry (including the in-flight head) has addr[31:2] == rd_addr[31:2]; this is a combinational compare across all entries.
REQ-022 Without DWB_RAW_CHECK_EN, raw_hit SHALL equal ~empty, a conservative stall with no comparators.

Structure
REQ-023 The entry struct (addr, wdata, wstrb, size) and the FSM state enum SHALL live in the shared CPU package alongside the TLB entry types.
REQ-024 FIFO storage and pointers SHALL be a sub-module, wbuf_fifo (push, pop, full, empty, head entry, flat entry/valid vectors for the compare).

Verification
REQ-025 Single store: push addr=0x1FAF_F000, data=0x1234_5678, strb=4'hF; awready=wready=1; bvalid arrives 2 cycles after W. Required: awvalid rises 1 cycle after push, then bready, then empty=1.
REQ-026 Fill: 5 pushes with DEPTH=4 and awready held 0. Required: req_ready=0 after the 4th push, the 5th push is held, and after awready=1 entries retire in push order.
REQ-027 Split handshake: wready=1 at cycle 0, awready=1 at cycle 3. Required: wvalid drops at cycle 1, awvalid stays high through cycle 3, and B is awaited only afterwards.
REQ-028 RAW: queue 0x1FD0_0004, query rd_addr=0x1FD0_0006. Required: raw_hit=1; rd_addr=0x1FD0_0008 gives raw_hit=0 with the macro and 1 without it.
REQ-029 Reset mid-WAIT_B with 3 entries queued. Required: next cycle empty=1, awvalid=0, and a subsequent push issues normally.
